adc_spi_responder: RTL



---
 rtl/adc_spi_responder_pkg.sv | 16 +
 rtl/adc_spi_responder_if.sv | 9 +
 rtl/adc_spi_responder_sync_edge.sv | 20 ++
 rtl/adc_spi_responder.sv | 106 ++++++++++
 4 files changed

// File: rtl/adc_spi_responder_pkg.sv
// adc_resp_pkg: shared constants, FSM states and channel lookup for the ADC SPI responder.
package adc_resp_pkg;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 3;
    localparam int NUM_CH = 8;
    localparam int LEAD_ZEROS = 4;
    localparam int FRAME_BITS = 16;
    localparam int ADDR_BIT_FIRST = 3;
    localparam int ADDR_BIT_LAST = 5;

    typedef enum logic {IDLE, ACTIVE} state_t;

    function automatic logic [DATA_W-1:0] ch_val(input logic [NUM_CH*DATA_W-1:0] d, input logic [ADDR_W-1:0] n);
        return d[32'(n)*DATA_W +: DATA_W];
    endfunction
endpackage

// File: rtl/adc_spi_responder_if.sv
// adc_spi_responder_if: serial link between the ADC master and the responder.
interface adc_spi_responder_if;
    logic ADC_CS_N;
    logic ADC_SCLK;
    logic ADC_DIN;
    logic ADC_DOUT;
    modport master(output ADC_CS_N, ADC_SCLK, ADC_DIN, input ADC_DOUT);
    modport slave(input ADC_CS_N, ADC_SCLK, ADC_DIN, output ADC_DOUT);
endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// adc_resp_sync_edge: input synchronizer with rise/fall detection on the last two synchronized samples.
module adc_resp_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [STAGES:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else ff <= {ff[STAGES-1:0], d};
    end

    assign rise = ff[STAGES-1] & ~ff[STAGES];
    assign fall = ~ff[STAGES-1] & ff[STAGES];
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: emulated 8-channel 12-bit serial ADC (ADC128S022-style responder).
// Define ADC_RESP_RAMP_EN to replace SAMPLE_DATA with an internal per-frame ramp.
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef ADC_RESP_RAMP_EN
    , parameter int RAMP_STEP = 1
`endif
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET,
    adc_spi_responder_if.slave            spi,
    input  logic [NUM_CH*DATA_W-1:0]      SAMPLE_DATA,
    output logic [ADDR_W-1:0]             CUR_ADDR,
    output logic                          FRAME_DONE,
    output logic                          FRAME_ERR
);
    state_t state;
    logic cs_rise, cs_fall, sclk_rise, sclk_fall, din_s, dout;
    logic [SYNC_STAGES-1:0] din_ff;
    logic [FRAME_BITS-1:0] sr;
    logic [4:0] rcnt, edge_n;
    logic [3:0] fcnt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] val_cur, val_nxt;

    adc_resp_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk(CLOCK_50), .rst(RESET), .d(spi.ADC_CS_N), .rise(cs_rise), .fall(cs_fall));
    adc_resp_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(CLOCK_50), .rst(RESET), .d(spi.ADC_SCLK), .rise(sclk_rise), .fall(sclk_fall));

    // DIN only needs the synchronizer; its tap lines up with the SCLK edge detector.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) din_ff <= '0;
        else din_ff <= {din_ff[SYNC_STAGES-2:0], spi.ADC_DIN};
    end
    assign din_s = din_ff[SYNC_STAGES-1];

`ifdef ADC_RESP_RAMP_EN
    logic [DATA_W-1:0] ramp;
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) ramp <= '0;
        else if (FRAME_DONE) ramp <= ramp + DATA_W'(RAMP_STEP);
    end
    assign val_cur = ramp + {CUR_ADDR, 9'd0};
    assign val_nxt = ramp + {addr_nxt, 9'd0};
`else
    assign val_cur = ch_val(SAMPLE_DATA, CUR_ADDR);
    assign val_nxt = ch_val(SAMPLE_DATA, addr_nxt);
`endif

    assign edge_n = rcnt + 5'd1;
    assign spi.ADC_DOUT = dout;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            sr <= '0;
            rcnt <= '0;
            fcnt <= '0;
            addr_nxt <= '0;
            CUR_ADDR <= '0;
            dout <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                IDLE: if (cs_fall) begin
                    sr <= {{LEAD_ZEROS{1'b0}}, val_cur};
                    rcnt <= '0;
                    fcnt <= '0;
                    dout <= 1'b0;
                    state <= ACTIVE;
                end
                ACTIVE: if (cs_rise) begin
                    FRAME_ERR <= rcnt != 5'd0;
                    dout <= 1'b0;
                    state <= IDLE;
                end else if (sclk_fall) begin
                    if (fcnt != 4'(FRAME_BITS-1)) begin
                        sr <= sr << 1;
                        dout <= sr[FRAME_BITS-2];
                        fcnt <= fcnt + 4'd1;
                    end
                end else if (sclk_rise) begin
                    rcnt <= edge_n;
                    if (edge_n >= 5'(ADDR_BIT_FIRST) && edge_n <= 5'(ADDR_BIT_LAST))
                        addr_nxt <= {addr_nxt[ADDR_W-2:0], din_s};
                    // Back-to-back frames: reload straight away while CS_N stays low.
                    if (edge_n == 5'(FRAME_BITS)) begin
                        CUR_ADDR <= addr_nxt;
                        FRAME_DONE <= 1'b1;
                        sr <= {{LEAD_ZEROS{1'b0}}, val_nxt};
                        dout <= 1'b0;
                        rcnt <= '0;
                        fcnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
